// File: rtl/conreg_pkg.sv
// ============================================================================
// Module  : conreg_pkg
// Purpose : Shared definitions for the conduit register bank: register word
//           indices, write-FSM state encoding and the address error decode.
// Ports   : none (package)
// Config  : CONREG_IRQ_EN is consumed by users of addr_err via irq_opt.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package conreg_pkg;

  // Word indices (byte address >> 2)
  localparam int unsigned IDX_ID       = 0;
  localparam int unsigned IDX_CTRL     = 1;
  localparam int unsigned IDX_STATUS   = 2;
  localparam int unsigned IDX_IRQ_STAT = 3;
  localparam int unsigned IDX_IRQ_EN   = 4;
  localparam int unsigned IDX_SCRATCH0 = 5;

  localparam int unsigned IRQ_BITS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } wr_state_t;

  // True when an access must be refused: misaligned, beyond the map, a
  // write to a read-only word, or an IRQ word while the IRQ block is absent.
  function automatic logic addr_err(input logic [31:0]  addr,
                                    input logic         is_wr,
                                    input int unsigned  num_regs,
                                    input logic         irq_opt);
    logic [31:0] idx;
    idx = {2'b00, addr[31:2]};
    return (addr[1:0] != 2'b00) ||
           (idx >= num_regs) ||
           (is_wr && ((idx == IDX_ID) || (idx == IDX_STATUS))) ||
           (!irq_opt && ((idx == IDX_IRQ_STAT) || (idx == IDX_IRQ_EN)));
  endfunction

endpackage

`default_nettype wire

// File: rtl/conreg_irq.sv
// ============================================================================
// Module  : conreg_irq
// Purpose : Sticky event capture for IRQ_STAT with write-one-to-clear and a
//           registered interrupt reduce against the enable mask.
// Ports   : hclk, hresetn   clock / async active-low reset
//           hw_event[7:0]   event pulses, each sets its IRQ_STAT bit
//           clr_en          a committed write to IRQ_STAT this edge
//           clr_data[7:0]   W1C mask of that write
//           irq_en[7:0]     enable mask
//           irq_stat[7:0]   sticky status
//           irq             registered |(irq_stat & irq_en)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module conreg_irq
  import conreg_pkg::*;
(
  input  logic                hclk,
  input  logic                hresetn,
  input  logic [IRQ_BITS-1:0] hw_event,
  input  logic                clr_en,
  input  logic [IRQ_BITS-1:0] clr_data,
  input  logic [IRQ_BITS-1:0] irq_en,
  output logic [IRQ_BITS-1:0] irq_stat,
  output logic                irq
);

  logic [IRQ_BITS-1:0] clr_mask;

  assign clr_mask = clr_en ? clr_data : '0;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      irq_stat <= '0;
      irq      <= 1'b0;
    end else begin
      // OR-ing the events in after the clear lets a same-edge event win.
      irq_stat <= (irq_stat & ~clr_mask) | hw_event;
      irq      <= |(irq_stat & irq_en);
    end
  end

endmodule

`default_nettype wire

// File: rtl/conduit_reg_bank.sv
// ============================================================================
// Module  : conduit_reg_bank
// Purpose : Conduit-side register bank behind the AHB slave adapter. Writes
//           are acknowledged after WAIT_CYCLES wait states; reads return on
//           the next edge. Exports CTRL, samples a hardware status word.
// Ports   : hclk, hresetn          clock / async active-low reset
//           con_wr, con_waddr, con_wdata   write request (held until ack)
//           con_rd, con_raddr      read request, 1-cycle latency
//           con_rdata, con_slverr  registered read data / error
//           con_wr_ack             one-cycle write completion pulse
//           hw_status              sampled into STATUS every edge
//           hw_event[7:0]          IRQ event pulses (IRQ option only)
//           ctrl_o                 CTRL contents
//           irq                    level interrupt (0 without the option)
// Config  : `define CONREG_IRQ_EN adds IRQ_STAT (W1C) / IRQ_EN and the irq
//           output; without it words 3/4 are error addresses.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module conduit_reg_bank
  import conreg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] ID_VALUE    = 32'hC0DE_0001
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  con_wr,
  input  logic                  con_rd,
  input  logic [ADDR_WIDTH-1:0] con_waddr,
  input  logic [ADDR_WIDTH-1:0] con_raddr,
  input  logic [DATA_WIDTH-1:0] con_wdata,
  output logic [DATA_WIDTH-1:0] con_rdata,
  output logic                  con_wr_ack,
  output logic                  con_slverr,
  input  logic [DATA_WIDTH-1:0] hw_status,
  input  logic [7:0]            hw_event,
  output logic [DATA_WIDTH-1:0] ctrl_o,
  output logic                  irq
);

  localparam int unsigned NUM_SCR   = NUM_REGS - IDX_SCRATCH0;
  localparam int unsigned SW        = (NUM_SCR > 1) ? $clog2(NUM_SCR) : 1;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
`ifdef CONREG_IRQ_EN
  localparam logic        IRQ_OPT   = 1'b1;
`else
  localparam logic        IRQ_OPT   = 1'b0;
`endif

  // Write path state
  wr_state_t               state, state_nx;
  logic [3:0]              cnt;
  logic [ADDR_WIDTH-3:0]   wr_word;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    wr_err;
  logic                    load;
  logic                    commit;
  logic [31:0]             wr_idx;
  logic [SW-1:0]           wr_sidx;

  // Read path
  logic [31:0]             rd_idx;
  logic [SW-1:0]           rd_sidx;
  logic                    rd_err_now;
  logic                    rd_err;
  logic [DATA_WIDTH-1:0]   rd_mux;

  // Register storage
  logic [DATA_WIDTH-1:0]   ctrl;
  logic [DATA_WIDTH-1:0]   status;
  logic [DATA_WIDTH-1:0]   scratch [NUM_SCR];
`ifdef CONREG_IRQ_EN
  logic [DATA_WIDTH-1:0]   irq_en;
  logic [IRQ_BITS-1:0]     irq_stat;
`endif

  assign wr_idx  = 32'(wr_word);
  assign wr_sidx = SW'(wr_idx - IDX_SCRATCH0);
  assign rd_idx  = 32'(con_raddr[ADDR_WIDTH-1:2]);
  assign rd_sidx = SW'(rd_idx - IDX_SCRATCH0);

  // --------------------------------------------------------------------------
  // Write FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    load       = 1'b0;
    con_wr_ack = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (con_wr) begin
          load     = 1'b1;
          state_nx = (WAIT_CYCLES == 0) ? ACK : WAIT;
        end
      end
      WAIT: begin
        // Requester withdrawing the write abandons it silently.
        if (!con_wr)             state_nx = IDLE;
        else if (cnt == 4'd1)    state_nx = ACK;
      end
      ACK: begin
        con_wr_ack = 1'b1;
        commit     = !wr_err;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Address, data and error are captured only on acceptance so the
  // requester may change them freely once the FSM has left IDLE.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      cnt     <= 4'd0;
      wr_word <= '0;
      wr_data <= '0;
      wr_err  <= 1'b0;
    end else if (load) begin
      cnt     <= WAIT_INIT;
      wr_word <= con_waddr[ADDR_WIDTH-1:2];
      wr_data <= con_wdata;
      wr_err  <= addr_err(32'(con_waddr), 1'b1, NUM_REGS, IRQ_OPT);
    end else if (state == WAIT) begin
      cnt     <= cnt - 4'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Register file
  // --------------------------------------------------------------------------
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      ctrl   <= '0;
      status <= '0;
      for (int i = 0; i < int'(NUM_SCR); i++) scratch[i] <= '0;
`ifdef CONREG_IRQ_EN
      irq_en <= '0;
`endif
    end else begin
      status <= hw_status;
      // commit implies a non-error write, so wr_idx is in range here.
      if (commit) begin
        if (wr_idx == IDX_CTRL)     ctrl             <= wr_data;
        if (wr_idx >= IDX_SCRATCH0) scratch[wr_sidx] <= wr_data;
`ifdef CONREG_IRQ_EN
        if (wr_idx == IDX_IRQ_EN)   irq_en           <= wr_data;
`endif
      end
    end
  end

  assign ctrl_o = ctrl;

  // --------------------------------------------------------------------------
  // Read path
  // --------------------------------------------------------------------------
  assign rd_err_now = addr_err(32'(con_raddr), 1'b0, NUM_REGS, IRQ_OPT);

  always_comb begin
    rd_mux = '0;
    if (rd_idx == IDX_ID)          rd_mux = DATA_WIDTH'(ID_VALUE);
    else if (rd_idx == IDX_CTRL)   rd_mux = ctrl;
    else if (rd_idx == IDX_STATUS) rd_mux = status;
`ifdef CONREG_IRQ_EN
    else if (rd_idx == IDX_IRQ_STAT) rd_mux = DATA_WIDTH'(irq_stat);
    else if (rd_idx == IDX_IRQ_EN)   rd_mux = irq_en;
`endif
    else if ((rd_idx >= IDX_SCRATCH0) && (rd_idx < NUM_REGS))
      rd_mux = scratch[rd_sidx];
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      con_rdata <= '0;
      rd_err    <= 1'b0;
    end else if (con_rd) begin
      con_rdata <= rd_err_now ? '0 : rd_mux;
      rd_err    <= rd_err_now;
    end else begin
      rd_err    <= 1'b0;
    end
  end

  // The write error owns the error line while the ack is out.
  assign con_slverr = (state == ACK) ? wr_err : rd_err;

  // --------------------------------------------------------------------------
  // Optional interrupt block
  // --------------------------------------------------------------------------
`ifdef CONREG_IRQ_EN
  conreg_irq u_irq (
    .hclk     (hclk),
    .hresetn  (hresetn),
    .hw_event (hw_event),
    .clr_en   (commit && (wr_idx == IDX_IRQ_STAT)),
    .clr_data (wr_data[IRQ_BITS-1:0]),
    .irq_en   (irq_en[IRQ_BITS-1:0]),
    .irq_stat (irq_stat),
    .irq      (irq)
  );
`else
  logic unused_hw_event;
  assign unused_hw_event = ^hw_event;
  assign irq             = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_conduit_reg_bank.sv
// ============================================================================
// Module  : tb_conduit_reg_bank
// Purpose : Self-checking bench for conduit_reg_bank: reset values, vector
//           table of reads/writes, write abort, reset mid-write, IRQ option
//           (when CONREG_IRQ_EN is defined), back-to-back writes.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_conduit_reg_bank;

  localparam int WAIT_CYCLES = 2;
`ifdef CONREG_IRQ_EN
  localparam bit OPT = 1'b1;
`else
  localparam bit OPT = 1'b0;
`endif

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        con_wr = 1'b0;
  logic        con_rd = 1'b0;
  logic [11:0] con_waddr = '0;
  logic [11:0] con_raddr = '0;
  logic [31:0] con_wdata = '0;
  logic [31:0] con_rdata;
  logic        con_wr_ack;
  logic        con_slverr;
  logic [31:0] hw_status = 32'h5A5A_1234;
  logic [7:0]  hw_event = '0;
  logic [31:0] ctrl_o;
  logic        irq;

  conduit_reg_bank #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (12),
    .NUM_REGS   (16),
    .WAIT_CYCLES(WAIT_CYCLES),
    .ID_VALUE   (32'hC0DE_0001)
  ) dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .con_wr    (con_wr),
    .con_rd    (con_rd),
    .con_waddr (con_waddr),
    .con_raddr (con_raddr),
    .con_wdata (con_wdata),
    .con_rdata (con_rdata),
    .con_wr_ack(con_wr_ack),
    .con_slverr(con_slverr),
    .hw_status (hw_status),
    .hw_event  (hw_event),
    .ctrl_o    (ctrl_o),
    .irq       (irq)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    string       name;
    logic        err;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    bit          wr;
    logic [11:0] addr;
    logic [31:0] data;   // write data, or expected read data
    logic        err;
    string       name;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Issue a write, wait for the ack and score slverr and latency.
  // ev_at_ack raises hw_event[0] so it coincides with the commit edge.
  task automatic do_write(input logic [11:0] a, input logic [31:0] d,
                          input logic err, input string name, input bit ev_at_ack);
    exp_t e;
    int   lat;
    bit   got;
    sb.push_back('{name: name, err: err, data: d});
    @(negedge hclk);
    con_wr = 1'b1; con_waddr = a; con_wdata = d;
    lat = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge hclk);
      lat++;
      if (con_wr_ack) got = 1'b1;
    end
    con_wr = 1'b0;
    if (ev_at_ack) hw_event = 8'h01;
    e = sb.pop_front();
    if (!got) chk({e.name, " ack timeout"}, 32'd0, 32'd1);
    else begin
      chk({e.name, " slverr"}, {31'b0, con_slverr}, {31'b0, e.err});
      chk({e.name, " latency"}, 32'(lat), 32'(WAIT_CYCLES + 1));
    end
    if (ev_at_ack) begin
      @(negedge hclk);
      hw_event = 8'h00;
    end
  endtask

  task automatic do_read(input logic [11:0] a, input logic [31:0] exp_d,
                         input logic err, input string name);
    exp_t e;
    sb.push_back('{name: name, err: err, data: exp_d});
    @(negedge hclk);
    con_rd = 1'b1; con_raddr = a;
    @(negedge hclk);
    con_rd = 1'b0;
    e = sb.pop_front();
    chk({e.name, " rdata"}, con_rdata, e.data);
    chk({e.name, " slverr"}, {31'b0, con_slverr}, {31'b0, e.err});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;

    // ---------------- reset values ----------------
    repeat (2) @(negedge hclk);
    chk("reset rdata",  con_rdata, 32'h0);
    chk("reset ack",    {31'b0, con_wr_ack}, 32'h0);
    chk("reset slverr", {31'b0, con_slverr}, 32'h0);
    chk("reset ctrl_o", ctrl_o, 32'h0);
    chk("reset irq",    {31'b0, irq}, 32'h0);
    hresetn = 1'b1;
    @(negedge hclk);

    // ---------------- CTRL write, commit on the ack edge ----------------
    do_write(12'h004, 32'hA5A5_0001, 1'b0, "wr CTRL", 1'b0);
    chk("ctrl_o before commit", ctrl_o, 32'h0);
    @(negedge hclk);
    chk("ctrl_o after ack", ctrl_o, 32'hA5A5_0001);

    // ---------------- vector table ----------------
    tbl.push_back('{1'b0, 12'h004, 32'hA5A5_0001, 1'b0, "rd CTRL"});
    tbl.push_back('{1'b0, 12'h000, 32'hC0DE_0001, 1'b0, "rd ID"});
    tbl.push_back('{1'b1, 12'h000, 32'h1234_5678, 1'b1, "wr ID"});
    tbl.push_back('{1'b0, 12'h000, 32'hC0DE_0001, 1'b0, "rd ID after wr"});
    tbl.push_back('{1'b1, 12'h002, 32'hDEAD_BEEF, 1'b1, "wr misaligned"});
    tbl.push_back('{1'b0, 12'h002, 32'h0000_0000, 1'b1, "rd misaligned"});
    tbl.push_back('{1'b1, 12'h040, 32'hDEAD_BEEF, 1'b1, "wr out of map"});
    tbl.push_back('{1'b0, 12'h040, 32'h0000_0000, 1'b1, "rd out of map"});
    tbl.push_back('{1'b0, 12'h004, 32'hA5A5_0001, 1'b0, "rd CTRL unchanged"});
    tbl.push_back('{1'b0, 12'h008, 32'h5A5A_1234, 1'b0, "rd STATUS"});
    tbl.push_back('{1'b1, 12'h008, 32'hFFFF_FFFF, 1'b1, "wr STATUS"});
    tbl.push_back('{1'b1, 12'h014, 32'h1111_1111, 1'b0, "wr SCRATCH0"});
    tbl.push_back('{1'b0, 12'h014, 32'h1111_1111, 1'b0, "rd SCRATCH0"});
    tbl.push_back('{1'b1, 12'h03C, 32'hF00D_000F, 1'b0, "wr last scratch"});
    tbl.push_back('{1'b0, 12'h03C, 32'hF00D_000F, 1'b0, "rd last scratch"});
    tbl.push_back('{1'b1, 12'h010, 32'h0000_0000, !OPT, "wr IRQ_EN"});
    tbl.push_back('{1'b0, 12'h010, 32'h0000_0000, !OPT, "rd IRQ_EN"});
    tbl.push_back('{1'b0, 12'h00C, 32'h0000_0000, !OPT, "rd IRQ_STAT"});
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].wr) do_write(tbl[i].addr, tbl[i].data, tbl[i].err, tbl[i].name, 1'b0);
      else           do_read (tbl[i].addr, tbl[i].data, tbl[i].err, tbl[i].name);
    end

    // ---------------- write aborted mid-WAIT ----------------
    @(negedge hclk);
    con_wr = 1'b1; con_waddr = 12'h014; con_wdata = 32'hBAD0_BAD0;
    acks = 0;
    repeat (2) begin @(negedge hclk); acks += int'(con_wr_ack); end
    con_wr = 1'b0;
    repeat (5) begin @(negedge hclk); acks += int'(con_wr_ack); end
    chk("abort no ack", 32'(acks), 32'd0);
    do_read(12'h014, 32'h1111_1111, 1'b0, "abort keeps SCRATCH0");

    // ---------------- interrupt ----------------
`ifdef CONREG_IRQ_EN
    do_write(12'h010, 32'h0000_0001, 1'b0, "wr IRQ_EN=1", 1'b0);
    @(negedge hclk); hw_event = 8'h01;
    @(negedge hclk); hw_event = 8'h00;
    @(negedge hclk);
    chk("irq after event", {31'b0, irq}, 32'd1);
    do_read(12'h00C, 32'h0000_0001, 1'b0, "rd IRQ_STAT set");
    do_write(12'h00C, 32'h0000_0001, 1'b0, "w1c with event", 1'b1);
    do_read(12'h00C, 32'h0000_0001, 1'b0, "rd IRQ_STAT set wins");
    chk("irq held", {31'b0, irq}, 32'd1);
    do_write(12'h00C, 32'h0000_0001, 1'b0, "w1c alone", 1'b0);
    repeat (2) @(negedge hclk);
    chk("irq cleared", {31'b0, irq}, 32'd0);
    do_read(12'h00C, 32'h0000_0000, 1'b0, "rd IRQ_STAT cleared");
`else
    @(negedge hclk); hw_event = 8'hFF;
    @(negedge hclk); hw_event = 8'h00;
    repeat (2) @(negedge hclk);
    chk("irq absent stays 0", {31'b0, irq}, 32'd0);
`endif

    // ---------------- back-to-back writes ----------------
    for (int i = 0; i < 4; i++)
      do_write(12'h014 + 12'(4 * i), 32'hC000_0000 + 32'(i * 32'h1111), 1'b0,
               $sformatf("b2b wr %0d", i), 1'b0);
    for (int i = 0; i < 4; i++)
      do_read(12'h014 + 12'(4 * i), 32'hC000_0000 + 32'(i * 32'h1111), 1'b0,
              $sformatf("b2b rd %0d", i));

    // ---------------- read on the commit edge returns old value ----------------
    do_write(12'h018, 32'h5555_AAAA, 1'b0, "wr SCRATCH1 new", 1'b0);
    con_rd = 1'b1; con_raddr = 12'h018;
    @(negedge hclk);
    con_rd = 1'b0;
    chk("rd on commit edge old", con_rdata, 32'hC000_1111);
    do_read(12'h018, 32'h5555_AAAA, 1'b0, "rd SCRATCH1 new");

    // ---------------- reset mid-WAIT ----------------
    @(negedge hclk);
    con_wr = 1'b1; con_waddr = 12'h014; con_wdata = 32'h7777_7777;
    acks = 0;
    @(negedge hclk);
    acks += int'(con_wr_ack);
    hresetn = 1'b0;
    @(negedge hclk);
    acks += int'(con_wr_ack);
    chk("reset ctrl_o cleared", ctrl_o, 32'h0);
    con_wr = 1'b0;
    hresetn = 1'b1;
    repeat (4) begin @(negedge hclk); acks += int'(con_wr_ack); end
    chk("reset mid-wait no ack", 32'(acks), 32'd0);
    do_read(12'h014, 32'h0000_0000, 1'b0, "reset SCRATCH0 discarded");
    do_read(12'h004, 32'h0000_0000, 1'b0, "reset CTRL");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
